// File: rtl/fp_pkg.sv
// Shared binary32 field helpers and integer-conversion constants for the FPU
// conversion path.
package fp_pkg;

  localparam logic [7:0]  FP_BIAS        = 8'd127;
  localparam logic [7:0]  FP_EXP_MAX     = 8'hFF;
  localparam logic [31:0] INT_INDEFINITE = 32'h8000_0000;
  // -2^31 is the only float with exponent 2^31 that fits in int32.
  localparam logic [31:0] FP_INT_MIN     = 32'hCF00_0000;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [22:0] fp_frac(input logic [31:0] x);
    return x[22:0];
  endfunction

endpackage

// File: rtl/f2i_core.sv
// Combinational binary32 -> int32 conversion, truncating toward zero,
// with precision-lost, denormal and invalid flags.
module f2i_core
  import fp_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] d_o,
  output logic        p_lost_o,
  output logic        denorm_o,
  output logic        invalid_o
);

  // Exponent codes where the binary point sits at bit 0, bit 30 and bit 31.
  localparam logic [7:0] E_POINT = FP_BIAS + 8'd23;
  localparam logic [7:0] E_LAST  = FP_BIAS + 8'd30;
  localparam logic [7:0] E_EDGE  = FP_BIAS + 8'd31;

  logic        sgn;
  logic [7:0]  e;
  logic [22:0] f;
  logic [31:0] mant;
  logic [4:0]  rsh;
  logic [4:0]  lsh;
  logic [31:0] mag;

  assign sgn  = fp_sign(a_i);
  assign e    = fp_exp(a_i);
  assign f    = fp_frac(a_i);
  assign mant = {8'd0, 1'b1, f};
  assign rsh  = 5'(E_POINT - e);
  assign lsh  = 5'(e - E_POINT);

  always_comb begin
    d_o       = 32'd0;
    p_lost_o  = 1'b0;
    denorm_o  = 1'b0;
    invalid_o = 1'b0;
    mag       = 32'd0;
    if (e == 8'd0) begin
      denorm_o = (f != 23'd0);
      p_lost_o = (f != 23'd0);
    end else if (e == FP_EXP_MAX) begin
      d_o       = INT_INDEFINITE;
      invalid_o = 1'b1;
    end else if (e < FP_BIAS) begin
      p_lost_o = 1'b1;
    end else if (e <= E_LAST) begin
      if (e >= E_POINT) begin
        mag = mant << lsh;
      end else begin
        mag      = mant >> rsh;
        p_lost_o = |(mant & ((32'd1 << rsh) - 32'd1));
      end
      d_o = sgn ? (~mag + 32'd1) : mag;
    end else if (e == E_EDGE && a_i == FP_INT_MIN) begin
      d_o = INT_INDEFINITE;
    end else begin
      d_o       = INT_INDEFINITE;
      invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/float_to_integer.sv
// cvt.w.s stage: combinational f2i_core followed by one output register,
// giving a fixed one-cycle latency at full throughput.
module float_to_integer
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  output logic [31:0] d,
  output logic        p_lost,
  output logic        denorm,
  output logic        invalid
);

  logic [31:0] d_d;
  logic        p_lost_d;
  logic        denorm_d;
  logic        invalid_d;
  logic [31:0] d_q;
  logic        p_lost_q;
  logic        denorm_q;
  logic        invalid_q;

  f2i_core u_core (
    .a_i       (a),
    .d_o       (d_d),
    .p_lost_o  (p_lost_d),
    .denorm_o  (denorm_d),
    .invalid_o (invalid_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q       <= 32'd0;
      p_lost_q  <= 1'b0;
      denorm_q  <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      d_q       <= d_d;
      p_lost_q  <= p_lost_d;
      denorm_q  <= denorm_d;
      invalid_q <= invalid_d;
    end
  end

  assign d       = d_q;
  assign p_lost  = p_lost_q;
  assign denorm  = denorm_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_float_to_integer.sv
// Bench for float_to_integer: reset behaviour, directed corner values and
// randomized back-to-back operands against an arithmetic reference model.
module tb_float_to_integer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = 32'd0;
  logic [31:0] d;
  logic        p_lost;
  logic        denorm;
  logic        invalid;

  int n_vec = 0;
  int n_err = 0;

  float_to_integer dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .d       (d),
    .p_lost  (p_lost),
    .denorm  (denorm),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  // Observed/expected are packed as {d, p_lost, denorm, invalid}.
  task automatic expect_eq(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got d=%h p=%b dn=%b inv=%b, expected d=%h p=%b dn=%b inv=%b",
               tag, got[34:3], got[2], got[1], got[0], exp[34:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [34:0] outs();
    return {d, p_lost, denorm, invalid};
  endfunction

  // Value = m * 2^(e-150); truncate toward zero, then range-check as int32.
  function automatic logic [34:0] ref_conv(input logic [31:0] x);
    int      e;
    int      k;
    longint  m;
    longint  mag;
    longint  pw;
    longint  v;
    bit      lost;
    e = int'(x[30:23]);
    m = longint'(x[22:0]) + 64'sd8388608;
    if (e == 0)
      return (x[22:0] != 0) ? {32'd0, 3'b110} : 35'd0;
    if (e == 255)
      return {32'h8000_0000, 3'b001};
    k = e - 127;
    if (k < 0)
      return {32'd0, 3'b100};
    if (k > 40)
      return {32'h8000_0000, 3'b001};
    lost = 1'b0;
    if (k >= 23) begin
      mag = m * (64'sd1 << (k - 23));
    end else begin
      pw   = 64'sd1 << (23 - k);
      mag  = m / pw;
      lost = (m % pw) != 0;
    end
    v = x[31] ? -mag : mag;
    if (v > 64'sd2147483647 || v < -64'sd2147483648)
      return {32'h8000_0000, 3'b001};
    return {v[31:0], lost, 2'b00};
  endfunction

  logic [31:0] dir_a [16] = '{
    32'h4effffff, 32'h3f800000, 32'h3fc00000, 32'h3f000000,
    32'hbf800000, 32'hbf7fffff, 32'hcf000000, 32'h4f000000,
    32'hcf000001, 32'h7f800000, 32'hff800000, 32'h7fc00000,
    32'h00000001, 32'h80000001, 32'h00000000, 32'h80000000
  };
  logic [34:0] dir_x [16] = '{
    {32'h7fffff80, 3'b000}, {32'h00000001, 3'b000}, {32'h00000001, 3'b100}, {32'h00000000, 3'b100},
    {32'hffffffff, 3'b000}, {32'h00000000, 3'b100}, {32'h80000000, 3'b000}, {32'h80000000, 3'b001},
    {32'h80000000, 3'b001}, {32'h80000000, 3'b001}, {32'h80000000, 3'b001}, {32'h80000000, 3'b001},
    {32'h00000000, 3'b110}, {32'h00000000, 3'b110}, {32'h00000000, 3'b000}, {32'h00000000, 3'b000}
  };

  initial begin
    logic [31:0] r;
    #1;
    expect_eq("reset_initial", outs(), 35'd0);
    @(negedge clk);
    rst = 1'b0;

    // Mid-stream asynchronous reset.
    a = 32'h3fc00000;
    @(posedge clk); #1;
    expect_eq("pre_reset", outs(), {32'd1, 3'b100});
    #2 rst = 1'b1;
    #1;
    expect_eq("reset_async", outs(), 35'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    expect_eq("reset_release", outs(), {32'd1, 3'b100});

    // Directed values back to back: a changes every cycle.
    for (int i = 0; i < 16; i++) begin
      a = dir_a[i];
      @(posedge clk); #1;
      expect_eq($sformatf("dir_%08h", dir_a[i]), outs(), dir_x[i]);
    end

    // Randomized back-to-back stream, exponents weighted toward the int32 range.
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      if (i % 4 != 0)
        r[30:23] = 8'($urandom_range(118, 162));
      if (i % 37 == 0)
        r[22:0] = 23'd0;
      a = r;
      @(posedge clk); #1;
      expect_eq($sformatf("rnd_%08h", r), outs(), ref_conv(r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
